// File: rtl/sif_bridge.sv
`default_nettype none
// ============================================================================
// Module   : sif_bridge
// Purpose  : SIF slave bridge. The xa (host) side writes and reads a local
//            register bank; every accepted xa write is also queued in a
//            write-forward FIFO and replayed on the wa side with a
//            ready/valid handshake. Provides backpressure (xa_busy), sticky
//            overflow reporting (xa_ovf) and configurable widths/depths.
// Ports    : clk, rst_n (sync, active-low)
//            xa_addr, xa_data_wr, xa_wr_s, xa_rd_s     host request
//            xa_data_rd, xa_rd_valid                    host read return
//            xa_busy, xa_ovf                            host flow status
//            wa_addr, wa_data_wr, wa_wr_s, wa_ready     forwarded writes
//            fifo_level                                 FIFO occupancy
//            drop_cnt (only with SIF_DROP_CNT_EN)       saturating drop count
// Options  : `define SIF_DROP_CNT_EN adds the drop_cnt[7:0] output.
// Revision : 1.0 - initial release
// ============================================================================
module sif_bridge #(
  parameter int AW         = 16,
  parameter int DW         = 16,
  parameter int NREGS      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [AW-1:0]                 xa_addr,
  input  logic [DW-1:0]                 xa_data_wr,
  input  logic                          xa_wr_s,
  input  logic                          xa_rd_s,
  output logic [DW-1:0]                 xa_data_rd,
  output logic                          xa_rd_valid,
  output logic                          xa_busy,
  output logic                          xa_ovf,
  output logic [AW-1:0]                 wa_addr,
  output logic [DW-1:0]                 wa_data_wr,
  output logic                          wa_wr_s,
  input  logic                          wa_ready,
`ifdef SIF_DROP_CNT_EN
  output logic [7:0]                    drop_cnt,
`endif
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int IW = (NREGS > 1) ? $clog2(NREGS) : 1;
  // NREGS extended by one bit so the range check covers the full address.
  localparam logic [AW:0]   NREGS_EXT = (AW+1)'(NREGS);
  localparam logic [LW-1:0] LVL_FULL  = LW'(FIFO_DEPTH);

  logic [DW-1:0] regs_q [NREGS];
  logic [AW-1:0] fa_q   [FIFO_DEPTH];
  logic [DW-1:0] fd_q   [FIFO_DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          ovf_q, ovf_d;
  logic          rd_valid_q;
  logic [DW-1:0] rd_data_q;

  logic          busy;
  logic          in_range;
  logic          push;
  logic          pop;
  logic [IW-1:0] reg_idx;

  // Full-width compare: high address bits never alias onto the bank.
  assign in_range = ({1'b0, xa_addr} < NREGS_EXT);
  assign reg_idx  = xa_addr[IW-1:0];

  always_comb begin
    busy     = (level_q == LVL_FULL);
    // Full blocks the write even if a pop happens on the same edge.
    push     = xa_wr_s & ~busy;
    pop      = (level_q != '0) & wa_ready;
    wr_ptr_d = push ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
    level_d  = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    ovf_d    = ovf_q | (xa_wr_s & busy);
  end

`ifdef SIF_DROP_CNT_EN
  logic [7:0] drop_cnt_q;
  assign drop_cnt = drop_cnt_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fa_q[i] <= '0;
        fd_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ovf_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
`ifdef SIF_DROP_CNT_EN
      drop_cnt_q <= '0;
`endif
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      ovf_q      <= ovf_d;
      rd_valid_q <= xa_rd_s;
      // Read samples the bank before this edge's write lands.
      if (xa_rd_s) rd_data_q <= in_range ? regs_q[reg_idx] : '0;
      if (push) begin
        fa_q[wr_ptr_q] <= xa_addr;
        fd_q[wr_ptr_q] <= xa_data_wr;
        if (in_range) regs_q[reg_idx] <= xa_data_wr;
      end
`ifdef SIF_DROP_CNT_EN
      if (xa_wr_s && busy && (drop_cnt_q != 8'hFF)) drop_cnt_q <= drop_cnt_q + 8'd1;
`endif
    end
  end

  assign xa_data_rd  = rd_data_q;
  assign xa_rd_valid = rd_valid_q;
  assign xa_busy     = busy;
  assign xa_ovf      = ovf_q;
  assign wa_wr_s     = (level_q != '0);
  // Head entry comes straight from registered storage, so it stays stable
  // while the downstream holds off.
  assign wa_addr     = fa_q[rd_ptr_q];
  assign wa_data_wr  = fd_q[rd_ptr_q];
  assign fifo_level  = level_q;

endmodule
`default_nettype wire

// File: tb/tb_sif_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_sif_bridge
// Purpose  : Self-checking bench for sif_bridge. A queue/array reference
//            model tracks the register bank and forward FIFO; one compare
//            process checks DUT outputs against it every cycle, and directed
//            scenarios pin literal expectations.
// Options  : honours SIF_DROP_CNT_EN (adds drop_cnt checking).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sif_bridge;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int NREGS = 16;
  localparam int DEPTH = 4;
  localparam int LW = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] xa_addr;
  logic [DW-1:0] xa_data_wr;
  logic          xa_wr_s;
  logic          xa_rd_s;
  logic [DW-1:0] xa_data_rd;
  logic          xa_rd_valid;
  logic          xa_busy;
  logic          xa_ovf;
  logic [AW-1:0] wa_addr;
  logic [DW-1:0] wa_data_wr;
  logic          wa_wr_s;
  logic          wa_ready;
  logic [LW-1:0] fifo_level;
`ifdef SIF_DROP_CNT_EN
  logic [7:0]    drop_cnt;
`endif

  sif_bridge #(.AW(AW), .DW(DW), .NREGS(NREGS), .FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .xa_addr     (xa_addr),
    .xa_data_wr  (xa_data_wr),
    .xa_wr_s     (xa_wr_s),
    .xa_rd_s     (xa_rd_s),
    .xa_data_rd  (xa_data_rd),
    .xa_rd_valid (xa_rd_valid),
    .xa_busy     (xa_busy),
    .xa_ovf      (xa_ovf),
    .wa_addr     (wa_addr),
    .wa_data_wr  (wa_data_wr),
    .wa_wr_s     (wa_wr_s),
    .wa_ready    (wa_ready),
`ifdef SIF_DROP_CNT_EN
    .drop_cnt    (drop_cnt),
`endif
    .fifo_level  (fifo_level)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0]    m_regs [NREGS];
  logic [AW+DW-1:0] m_q [$];
  bit               m_ovf;
  bit               m_rd_valid;
  logic [DW-1:0]    m_rd_data;
  int               m_drop;

  always @(posedge clk) begin
    if (rst_n !== 1'b1) begin
      foreach (m_regs[i]) m_regs[i] = '0;
      m_q.delete();
      m_ovf = 0; m_rd_valid = 0; m_rd_data = '0; m_drop = 0;
    end else begin
      bit full, do_pop, do_push;
      full    = (m_q.size() == DEPTH);
      do_pop  = (m_q.size() != 0) && wa_ready;
      do_push = xa_wr_s && !full;
      m_rd_valid = xa_rd_s;
      if (xa_rd_s) m_rd_data = (int'(xa_addr) < NREGS) ? m_regs[int'(xa_addr)] : '0;
      if (do_push && int'(xa_addr) < NREGS) m_regs[int'(xa_addr)] = xa_data_wr;
      if (xa_wr_s && full) begin
        m_ovf = 1;
        if (m_drop < 255) m_drop++;
      end
      if (do_pop) void'(m_q.pop_front());
      if (do_push) m_q.push_back({xa_addr, xa_data_wr});
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("rd_valid", 32'(xa_rd_valid), 32'(m_rd_valid));
      cmp("rd_data", 32'(xa_data_rd), 32'(m_rd_data));
      cmp("level", 32'(fifo_level), 32'(m_q.size()));
      cmp("busy", 32'(xa_busy), 32'(m_q.size() == DEPTH));
      cmp("ovf", 32'(xa_ovf), 32'(m_ovf));
      cmp("wa_wr_s", 32'(wa_wr_s), 32'(m_q.size() != 0));
      if (m_q.size() != 0) begin
        cmp("wa_addr", 32'(wa_addr), 32'(m_q[0][AW+DW-1:DW]));
        cmp("wa_data", 32'(wa_data_wr), 32'(m_q[0][DW-1:0]));
      end
`ifdef SIF_DROP_CNT_EN
      cmp("drop_cnt", 32'(drop_cnt), 32'(m_drop));
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle();
    xa_wr_s = 0; xa_rd_s = 0; xa_addr = '0; xa_data_wr = '0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    xa_wr_s = 1; xa_rd_s = 0; xa_addr = a; xa_data_wr = d;
  endtask

  task automatic rd(input logic [AW-1:0] a);
    xa_wr_s = 0; xa_rd_s = 1; xa_addr = a;
  endtask

  task automatic check_all_zero(input string tag);
    cmp({tag, "_rd_data"}, 32'(xa_data_rd), 0);
    cmp({tag, "_rd_valid"}, 32'(xa_rd_valid), 0);
    cmp({tag, "_busy"}, 32'(xa_busy), 0);
    cmp({tag, "_ovf"}, 32'(xa_ovf), 0);
    cmp({tag, "_wa_wr_s"}, 32'(wa_wr_s), 0);
    cmp({tag, "_wa_addr"}, 32'(wa_addr), 0);
    cmp({tag, "_wa_data"}, 32'(wa_data_wr), 0);
    cmp({tag, "_level"}, 32'(fifo_level), 0);
  endtask

  initial begin
    logic [AW-1:0] a;
    rst_n = 0; wa_ready = 0; idle();

    // 1: reset with random inputs
    for (int i = 0; i < 5; i++) begin
      xa_wr_s = 1'($urandom); xa_rd_s = 1'($urandom);
      xa_addr = AW'($urandom); xa_data_wr = DW'($urandom);
      wa_ready = 1'($urandom);
      cyc();
    end
    check_all_zero("rst");
    rst_n = 1; idle(); wa_ready = 0;
    chk_en = 1;
    cyc();
    check_all_zero("post_rst");

    // 2: write then read
    wa_ready = 1;
    wr(16'd3, 16'hA5A5); cyc();
    cmp("t2_wa_wr_s", 32'(wa_wr_s), 1);
    cmp("t2_wa_addr", 32'(wa_addr), 3);
    cmp("t2_wa_data", 32'(wa_data_wr), 32'hA5A5);
    rd(16'd3); cyc();
    cmp("t2_wa_wr_s_done", 32'(wa_wr_s), 0);
    cmp("t2_rd_valid", 32'(xa_rd_valid), 1);
    cmp("t2_rd_data", 32'(xa_data_rd), 32'hA5A5);
    idle(); cyc();
    cmp("t2_rd_valid_low", 32'(xa_rd_valid), 0);
    cmp("t2_rd_hold", 32'(xa_data_rd), 32'hA5A5);

    // 3: backpressure and overflow
    wa_ready = 0;
    for (int i = 1; i <= 5; i++) begin
      wr(AW'(8 + i), DW'(i)); cyc();
    end
    cmp("t3_level", 32'(fifo_level), 4);
    cmp("t3_busy", 32'(xa_busy), 1);
    cmp("t3_ovf", 32'(xa_ovf), 1);
`ifdef SIF_DROP_CNT_EN
    cmp("t3_drop_cnt", 32'(drop_cnt), 1);
`endif
    idle(); wa_ready = 1;
    for (int k = 1; k <= 4; k++) begin
      cmp("t3_wa_wr_s", 32'(wa_wr_s), 1);
      cmp("t3_wa_seq", 32'(wa_data_wr), 32'(k));
      cyc();
    end
    cmp("t3_empty", 32'(wa_wr_s), 0);
    cmp("t3_ovf_sticky", 32'(xa_ovf), 1);

    // 4: same-address read/write collision
    wr(16'd7, 16'h0011); cyc();
    wr(16'd7, 16'h0022); xa_rd_s = 1; cyc();
    cmp("t4_old", 32'(xa_data_rd), 32'h0011);
    cmp("t4_old_valid", 32'(xa_rd_valid), 1);
    rd(16'd7); cyc();
    cmp("t4_new", 32'(xa_data_rd), 32'h0022);
    idle(); cyc();

    // 5: out-of-range write is forward-only
    wr(16'h0020, 16'hBEEF); cyc();
    cmp("t5_wa_wr_s", 32'(wa_wr_s), 1);
    cmp("t5_wa_addr", 32'(wa_addr), 32'h0020);
    cmp("t5_wa_data", 32'(wa_data_wr), 32'hBEEF);
    rd(16'h0020); cyc();
    cmp("t5_rd_zero", 32'(xa_data_rd), 0);
    rd(16'h0000); cyc();
    cmp("t5_no_alias", 32'(xa_data_rd), 0);
    idle(); cyc();

    // 6: reset mid-operation
    wa_ready = 0;
    for (int i = 0; i < 3; i++) begin
      wr(AW'(i), DW'(16'h100 + i)); cyc();
    end
    cmp("t6_level3", 32'(fifo_level), 3);
    idle(); rst_n = 0; cyc();
    cmp("t6_level0", 32'(fifo_level), 0);
    cmp("t6_wa_wr_s", 32'(wa_wr_s), 0);
    cmp("t6_ovf", 32'(xa_ovf), 0);
    rst_n = 1; wa_ready = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      cmp("t6_no_stale", 32'(wa_wr_s), 0);
    end

    // Randomised traffic against the model
    for (int c = 0; c < 4000; c++) begin
      a = AW'($urandom_range(0, NREGS + 3));
      if ($urandom_range(0, 9) == 0) a = AW'($urandom);
      xa_addr    = a;
      xa_data_wr = DW'($urandom);
      xa_wr_s    = ($urandom_range(0, 99) < 55);
      xa_rd_s    = ($urandom_range(0, 99) < 40);
      wa_ready   = ($urandom_range(0, 99) < 45);
      rst_n      = ($urandom_range(0, 299) != 0);
      cyc();
    end
    idle(); rst_n = 1;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
